// File: rtl/lc3b_mem_ctrl_if.sv
// LC-3b memory port bundle.
// Controller drives the request side, memory answers with data/ack.
interface lc3b_mem_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_be,
    output mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_be,
    input  mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lc3b_mem_ctrl.sv
// LC-3b memory-access sequencer.
// One handshaked access per L/S request, with status and timeout.
module lc3b_mem_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        L,
  input  logic        S,
  input  logic        word,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        done,
  output logic [1:0]  err,
  lc3b_mem_ctrl_if.master mem
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, DONE, RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t      state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]  err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] addr_q, wdata_q;
  logic        word_q, op_ld, lat;
  logic        req;

  // State register; async reset drops mem_req at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Request latch, wait counter, status and load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      err_q   <= 2'b00;
      rdata_q <= 16'h0000;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      word_q  <= 1'b0;
      op_ld   <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (lat) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        word_q  <= word;
        op_ld   <= L;
      end
    end
  end

  // Next-state, counter, status and load-data selection.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    err_d   = err_q;
    rdata_d = rdata_q;
    lat     = 1'b0;
    unique case (state)
      IDLE: begin
        if (L || S) begin
          lat   = 1'b1;
          cnt_d = '0;
          if (L && S) begin
            state_d = DONE;
            err_d   = 2'b11;
          end else if (word && addr[0]) begin
            state_d = DONE;
            err_d   = 2'b01;
          end else begin
            state_d = ACCESS;
            err_d   = 2'b00;
          end
        end
      end
      ACCESS: begin
        if (mem.mem_ack) begin
          state_d = DONE;
          err_d   = 2'b00;
          if (op_ld) begin
            if (word_q)
              rdata_d = mem.mem_rdata;
            else if (addr_q[0])
              rdata_d = {8'h00, mem.mem_rdata[15:8]};
            else
              rdata_d = {8'h00, mem.mem_rdata[7:0]};
          end
        end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
          state_d = DONE;
          err_d   = 2'b10;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: state_d = RELEASE;
      RELEASE: begin
        if (!L && !S) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port is driven only while a request is outstanding.
  always_comb begin
    req           = (state == ACCESS);
    mem.mem_req   = req;
    mem.mem_we    = req & ~op_ld;
    mem.mem_be    = 2'b00;
    mem.mem_addr  = 15'h0000;
    mem.mem_wdata = 16'h0000;
    if (req) begin
      mem.mem_addr = addr_q[15:1];
      if (word_q) begin
        mem.mem_be    = 2'b11;
        mem.mem_wdata = wdata_q;
      end else begin
        mem.mem_be    = addr_q[0] ? 2'b10 : 2'b01;
        mem.mem_wdata = {wdata_q[7:0], wdata_q[7:0]};
      end
    end
  end

  assign done  = (state == DONE);
  assign err   = done ? err_q : 2'b00;
  assign rdata = rdata_q;

endmodule
